// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CHECK = 3'd2,
      ERR   = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int IMEM_DEPTH_DEFAULT = 128;

endpackage

// File: rtl/imem_loader.sv
// Instruction-memory loader: streams program bytes into a byte-wide
// instruction memory and holds the core in reset until a load completes.
// Build option: define IMEM_LOADER_CSUM_EN to require a trailing modulo-256
// checksum byte after the program; a mismatch parks the loader in ERR.
//
// state | meaning
// IDLE  | after reset, waiting for start
// LOAD  | accepting program bytes, one memory write per accepted byte
// CHECK | waiting for the checksum byte (checksum build only)
// ERR   | checksum mismatch, core kept in reset (checksum build only)
// DONE  | program loaded, core reset released one cycle after entry
module imem_loader
   import imem_pkg::*;
#(
   parameter int DEPTH  = IMEM_DEPTH_DEFAULT,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        load_len,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              cpu_rst_n
);

   state_t            state;
   logic [7:0]        count;
   logic [7:0]        len_q;
   logic              xfer;
   logic              last_byte;
   logic              can_start;
   logic [ADDR_W-1:0] wr_addr;

`ifdef IMEM_LOADER_CSUM_EN
   logic [7:0]        csum;

   assign byte_ready = (state == LOAD) || (state == CHECK);
   assign err        = (state == ERR);
   assign can_start  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
`else
   assign byte_ready = (state == LOAD);
   assign err        = 1'b0;
   assign can_start  = start && ((state == IDLE) || (state == DONE));
`endif

   assign busy      = byte_ready;
   assign done      = (state == DONE);
   assign xfer      = byte_valid && byte_ready;
   assign last_byte = (count == (len_q - 8'd1));
   // DEPTH is a power of two, so masking gives count mod DEPTH
   assign wr_addr   = ADDR_W'(count) & ADDR_W'(DEPTH - 1);

   // Sequencer: state, byte counter, checksum and registered memory strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         count     <= 8'd0;
         len_q     <= 8'd0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 8'd0;
         cpu_rst_n <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
         csum      <= 8'd0;
`endif
      end else begin
         mem_we    <= 1'b0;
         // a restart from DONE pulls the core back into reset on the next cycle
         cpu_rst_n <= (state == DONE) && !can_start;
         if (can_start) begin
            count <= 8'd0;
            len_q <= load_len;
`ifdef IMEM_LOADER_CSUM_EN
            csum  <= 8'd0;
`endif
            state <= (load_len == 8'd0) ? DONE : LOAD;
         end else begin
            case (state)
               LOAD: begin
                  if (xfer) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= wr_addr;
                     mem_wdata <= byte_data;
                     count     <= count + 8'd1;
`ifdef IMEM_LOADER_CSUM_EN
                     csum      <= csum + byte_data;
                     if (last_byte) state <= CHECK;
`else
                     if (last_byte) state <= DONE;
`endif
                  end
               end
`ifdef IMEM_LOADER_CSUM_EN
               CHECK: begin
                  if (xfer) state <= (byte_data == csum) ? DONE : ERR;
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a per-cycle vector table plus a hand-written
// mid-load reset sequence. A second instance with DEPTH=4 shares the stimulus
// so address wrap-around is checked on the same loads.
module tb_imem_loader;

`ifdef IMEM_LOADER_CSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  load_len = 8'd0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'd0;

   logic        byte_ready, mem_we, busy, done, err, cpu_rst_n;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;

   logic        byte_ready4, mem_we4, busy4, done4, err4, cpu_rst_n4;
   logic [31:0] mem_addr4;
   logic [7:0]  mem_wdata4;

   imem_loader #(.DEPTH(128), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .err(err), .cpu_rst_n(cpu_rst_n)
   );

   imem_loader #(.DEPTH(4), .ADDR_W(32)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready4),
      .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
      .busy(busy4), .done(done4), .err(err4), .cpu_rst_n(cpu_rst_n4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        start;
      logic [7:0]  len;
      logic        valid;
      logic [7:0]  data;
      logic        we;
      logic [31:0] addr;
      logic [31:0] addr4;
      logic [7:0]  wdata;
      logic        busy;
      logic        done;
      logic        err;
      logic        crst;
      logic        ready;
      logic        chk_bus;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] pb [0:15];
   int         n_vec = 0;
   int         n_bad = 0;

   function automatic vec_t mk(input int rs, input int st, input int ln, input int vl,
                               input int dt, input int we, input int ad, input int ad4,
                               input int wd, input int bs, input int dn, input int er,
                               input int cr, input int rd);
      vec_t t;
      t.rst_n   = (rs != 0);
      t.start   = (st != 0);
      t.len     = 8'(ln);
      t.valid   = (vl != 0);
      t.data    = 8'(dt);
      t.we      = (we != 0);
      t.addr    = 32'(ad);
      t.addr4   = 32'(ad4);
      t.wdata   = 8'(wd);
      t.busy    = (bs != 0);
      t.done    = (dn != 0);
      t.err     = (er != 0);
      t.crst    = (cr != 0);
      t.ready   = (rd != 0);
      t.chk_bus = (rs == 0);
      return t;
   endfunction

   task automatic v(input int rs, input int st, input int ln, input int vl, input int dt,
                    input int we, input int ad, input int ad4, input int wd,
                    input int bs, input int dn, input int er, input int cr, input int rd);
      vecs.push_back(mk(rs, st, ln, vl, dt, we, ad, ad4, wd, bs, dn, er, cr, rd));
   endtask

   // One load of n bytes from pb[]; gapped inserts an idle cycle (with a
   // start that must be ignored) before every byte after the first.
   task automatic gen_load(input int n, input bit gapped, input bit bad);
      logic [7:0] sum;
      logic [7:0] ck;
      int         fin;
      int         ok;
      sum = 8'd0;
      for (int i = 0; i < n; i++) sum = sum + pb[i];
      ck = bad ? sum - 8'd1 : sum;
      ok = (CSUM && bad) ? 0 : 1;
      v(1, 1, n, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      for (int i = 0; i < n; i++) begin
         if (gapped && i > 0) v(1, 1, 2, 0, 8'h5A, 0, 0, 0, 0, 1, 0, 0, 0, 1);
         fin = (i == n - 1 && !CSUM) ? 1 : 0;
         v(1, 0, 0, 1, int'(pb[i]), 1, i, i % 4, int'(pb[i]), 1 - fin, fin, 0, 0, 1 - fin);
      end
      if (CSUM) v(1, 0, 0, 1, int'(ck), 0, 0, 0, 0, 0, ok, 1 - ok, 0, 0);
      v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ok, 1 - ok, ok, 0);
   endtask

   task automatic check_vec(input string name, input vec_t e);
      bit good;
      good = (mem_we === e.we) && (mem_we4 === e.we) && (busy === e.busy) &&
             (done === e.done) && (err === e.err) && (cpu_rst_n === e.crst) &&
             (byte_ready === e.ready);
      if (e.we || e.chk_bus)
         good = good && (mem_addr === e.addr) && (mem_wdata === e.wdata) &&
                (mem_addr4 === e.addr4);
      n_vec++;
      if (!good) begin
         n_bad++;
         $display("FAIL %s: got we=%0b addr=%0h addr4=%0h wdata=%02h busy=%0b done=%0b err=%0b cpu_rst_n=%0b ready=%0b; want we=%0b addr=%0h addr4=%0h wdata=%02h busy=%0b done=%0b err=%0b cpu_rst_n=%0b ready=%0b",
                  name, mem_we, mem_addr, mem_addr4, mem_wdata, busy, done, err, cpu_rst_n, byte_ready,
                  e.we, e.addr, e.addr4, e.wdata, e.busy, e.done, e.err, e.crst, e.ready);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- table construction ----------------
      v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      pb[0] = 8'h13; pb[1] = 8'h05; pb[2] = 8'h00; pb[3] = 8'h01;
      gen_load(4, 1'b0, 1'b0);
      // bytes offered while DONE are not accepted
      v(1, 0, 0, 1, 8'hAA, 0, 0, 0, 0, 0, 1, 0, 1, 0);

      gen_load(4, 1'b1, 1'b0);

      // zero-length load: straight to DONE, core reset pulsed low for one cycle
      v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);

      for (int i = 0; i < 6; i++) pb[i] = 8'(8'h10 + i);
      gen_load(6, 1'b0, 1'b0);

      if (CSUM) begin
         pb[0] = 8'h13; pb[1] = 8'h05; pb[2] = 8'h00; pb[3] = 8'h01;
         gen_load(4, 1'b0, 1'b1);
         gen_load(4, 1'b0, 1'b0);
      end

      // ---------------- table application ----------------
      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clk);
         rst_n      = vecs[k].rst_n;
         start      = vecs[k].start;
         load_len   = vecs[k].len;
         byte_valid = vecs[k].valid;
         byte_data  = vecs[k].data;
         @(posedge clk);
         #1;
         check_vec($sformatf("vec%0d", k), vecs[k]);
      end

      // ---------------- reset in the middle of a load ----------------
      @(negedge clk);
      start = 1'b1; load_len = 8'd4; byte_valid = 1'b0; byte_data = 8'h00;
      @(negedge clk);
      start = 1'b0; byte_valid = 1'b1; byte_data = 8'h13;
      @(negedge clk);
      byte_data = 8'h05;
      @(posedge clk);
      #1;
      check_vec("mid_load_write", mk(1, 0, 0, 1, 5, 1, 1, 1, 5, 1, 0, 0, 0, 1));
      #2;
      rst_n = 1'b0;
      byte_data = 8'h77;
      #1;
      check_vec("async_reset", mk(0, 0, 0, 1, 8'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      check_vec("reset_held", mk(0, 0, 0, 1, 8'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_vec($sformatf("post_reset_idle%0d", i),
                   mk(1, 0, 0, 1, 8'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      byte_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
